uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   Serializes parallel logger words onto an async UART line (8N1-style framing,
//   LSB first). Consumes words from the sample/packet path via valid/ready.
//   Sits downstream of the capture registers and feeds the board's USB-UART
//   bridge. Internally built from a bit-period counter, a bit index counter and
//   a shift register.
// PARAMETERS
//   DATA_WIDTH    8    payload bits per frame, 5..9
//   CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200), >= 2
//   STOP_BITS     1    number of stop bits, 1 or 2
//   PARITY_ODD    0    0 = even, 1 = odd parity. Used only with PARITY_EN.
// PORTS
//   clk    in   1           system clock; all logic on posedge
//   clr    in   1           synchronous, active-high reset
//   data   in   DATA_WIDTH  word to send; sampled only on handshake
//   valid  in   1           upstream has a word
//   ready  out  1           block can accept a word (IDLE only)
//   busy   out  1           frame in progress (inverse of ready)
//   tx     out  1           serial line, idle high
// BEHAVIOUR
// - All outputs are registered. While clr = 1, and on the edge after it drops:
//   state = IDLE, tx = 1, ready = 1, busy = 0, and all counters = 0.
// - Handshake: valid & ready at a posedge captures data into the shift register.
//   The block leaves IDLE at that edge. data/valid are don't-care afterwards.
//   valid while busy is ignored; no word is queued.
// - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - START: tx = 0 for CLKS_PER_BIT cycles. tx falls on the edge that
//     captures data, so latency from handshake edge to start bit is 0 cycles.
//   - DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
//     The shift register shifts right at each bit boundary.
//   - PARITY: see CONFIGURATION.
//   - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then -> IDLE with ready = 1.
// - Bit-period counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit
//   boundary. Width is $clog2(CLKS_PER_BIT).
// - Bit index counter counts 0..DATA_WIDTH-1 in DATA and is cleared on every
//   state change.
// - Frame length = (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where
//   P = 1 with PARITY_EN, else 0.
// - Back-to-back: with valid held high, the next start bit begins exactly 1 cycle
//   after the last stop-bit cycle. The IDLE cycle is the handshake cycle.
// - clr mid-frame aborts immediately. tx = 1 at the next edge, the partial frame
//   is dropped, and no stop bit is appended.
// - tx never glitches. It changes only at bit boundaries and on handshake/clr edges.
// CONFIGURATION
// - Macro PARITY_EN:
//   - Defined: a PARITY state follows DATA. tx = XOR of captured data bits,
//     inverted when PARITY_ODD = 1, held CLKS_PER_BIT cycles. Parity is computed
//     from the word captured at handshake.
//   - Not defined: no PARITY state and no parity logic. DATA goes directly to
//     STOP, and PARITY_ODD is ignored.
// TESTING (CLKS_PER_BIT = 4, DATA_WIDTH = 8, STOP_BITS = 1 unless stated)
// - Reset: assert clr 3 cycles with valid = 1 -> tx = 1, ready = 1, busy = 0,
//   and no start bit while clr is high.
// - Single frame data = 8'hA5: tx = 0, then 1,0,1,0,0,1,0,1, then 1, each for
//   4 cycles. ready = 0 for 40 cycles, then 1.
// - Back-to-back 8'h00 then 8'hFF, valid held: the second start bit falls
//   exactly 1 cycle after the first frame's last stop cycle. Second frame bits
//   are all 1.
// - Ignore while busy: pulse valid with 8'h3C mid-frame of 8'h81 -> only 8'h81
//   is emitted, and ready = 1 afterwards with no second frame.
// - Abort: clr during bit 3 of 8'hF0 -> tx = 1 at the next edge, ready = 1.
//   A fresh 8'h55 afterwards frames correctly.
// - PARITY_EN, PARITY_ODD = 0: 8'hA5 -> parity bit 0 and frame length 44 cycles.
//   8'h07 -> parity bit 1. STOP_BITS = 2 gives stop high for 8 cycles.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// UartTxSerializer (module uart_tx_serializer)
//
// Purpose:
//   Serializes parallel logger words onto an asynchronous UART line using
//   8N1-style framing, LSB first. Words arrive from the capture path through a
//   valid/ready handshake. The serial output feeds the board's USB-UART bridge.
//   The datapath consists of a bit-period counter, a bit index counter and a
//   shift register.
//
// Optional feature:
//   Define the macro PARITY_EN to insert a parity bit between the data bits
//   and the stop bit(s). PARITY_ODD selects odd (1) or even (0) parity. When
//   PARITY_EN is undefined, there is no parity state or parity logic, and
//   PARITY_ODD has no effect.
//
// Parameters:
//   DATA_WIDTH    payload bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity (PARITY_EN builds only)
//
// Ports:
//   clk    in   system clock; all logic runs on posedge
//   clr    in   synchronous, active-high reset; aborts any frame in progress
//   data   in   word to send; sampled only on the handshake edge
//   valid  in   upstream has a word
//   ready  out  block can accept a word (high only in IDLE)
//   busy   out  frame in progress (inverse of ready)
//   tx     out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  busy,
  output logic                  tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2((DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS);

  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         bit_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  bit_end;
  logic                  handshake;
  logic                  tx_next;
  logic                  ready_next;
  logic                  busy_next;
`ifdef PARITY_EN
  logic                  par_bit;
  logic                  par_next;
`endif

  // A bit boundary is the final cycle of the current bit period. The counter
  // rests at zero in IDLE, so this stays low there because CLKS_PER_BIT >= 2.
  assign bit_end   = (bit_cnt == LAST_CNT);
  assign handshake = (state == S_IDLE) && valid;

  // State register together with the counters, datapath and registered outputs.
  // Outputs take the values computed for the state being entered, so tx falls
  // on the same edge that captures the word. The line changes only at bit
  // boundaries or on handshake and clr edges.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      tx        <= tx_next;
      ready     <= ready_next;
      busy      <= busy_next;
      shift_reg <= shift_next;
`ifdef PARITY_EN
      par_bit   <= par_next;
`endif

      // The bit-period counter wraps at every boundary and on every state
      // change. It stays at zero while IDLE.
      if ((state_next != state) || bit_end) begin
        bit_cnt <= '0;
      end else if (state != S_IDLE) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // The bit index counts data bits in DATA and stop bits in STOP. Every
      // state change clears it.
      if (state_next != state) begin
        bit_idx <= '0;
      end else if (bit_end && ((state == S_DATA) || (state == S_STOP))) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Next-state logic. A valid word seen while not IDLE is ignored and is not
  // queued.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (valid) state_next = S_START;
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == LAST_DATA)) begin
`ifdef PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end && (bit_idx == LAST_STOP)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath next values. The word and its parity are captured at the
  // handshake. The shift register moves right only at data-bit boundaries,
  // so bit 0 is still in place when DATA is entered from START.
  always_comb begin
    shift_next = shift_reg;
    if (handshake) begin
      shift_next = data;
    end else if ((state == S_DATA) && bit_end) begin
      shift_next = shift_reg >> 1;
    end
  end

`ifdef PARITY_EN
  always_comb begin
    par_next = par_bit;
    if (handshake) begin
      par_next = (^data) ^ (PARITY_ODD != 0);
    end
  end
`endif

  // Output logic. This computes the line level and the handshake flags for
  // the state being entered. The state register block then registers them.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef PARITY_EN
      S_PARITY: tx_next = par_next;
`endif
      default:  tx_next = 1'b1;
    endcase
    ready_next = (state_next == S_IDLE);
    busy_next  = (state_next != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// TbUartTxSerializer (module tb_uart_tx_serializer)
//
// Purpose:
//   Directed, self-checking bench for uart_tx_serializer with CLKS_PER_BIT = 4
//   and DATA_WIDTH = 8. A second instance with STOP_BITS = 2 covers the long
//   stop period. Expected line levels come from a bench-side frame model.
//   The model inserts a parity bit when PARITY_EN is defined.
//
// Ports:
//   none (top-level bench)
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FL1 = (1 + DW + PB + 1) * CPB;
  localparam int FL2 = (1 + DW + PB + 2) * CPB;

  logic          clk;
  logic          clr;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          tx;
  logic [DW-1:0] data2;
  logic          valid2;
  logic          ready2;
  logic          busy2;
  logic          tx2;

  int total;
  int bad;

  uart_tx_serializer #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk  (clk),
    .clr  (clr),
    .data (data),
    .valid(valid),
    .ready(ready),
    .busy (busy),
    .tx   (tx)
  );

  uart_tx_serializer #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (2),
    .PARITY_ODD  (0)
  ) dut2 (
    .clk  (clk),
    .clr  (clr),
    .data (data2),
    .valid(valid2),
    .ready(ready2),
    .busy (busy2),
    .tx   (tx2)
  );

  // Free-running clock with a 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level expected for bit slot idx of a frame carrying word w.
  // Slot 0 is the start bit, then the data bits LSB first, then an optional
  // even-parity bit. Every slot after that is a stop bit.
  function automatic logic expBit(input logic [DW-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
`ifdef PARITY_EN
    if (idx == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Drive the main instance's inputs
  task automatic applyStimulus(input logic [DW-1:0] d, input logic v, input logic r);
    data  = d;
    valid = v;
    clr   = r;
  endtask

  // One counted comparison; a mismatch is counted and reported
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and check that the main instance is IDLE
  task automatic idleCheck(input string tag);
    @(posedge clk); #1;
    checkOutput({tag, " tx"}, tx, 1'b1);
    checkOutput({tag, " ready"}, ready, 1'b1);
    checkOutput({tag, " busy"}, busy, 1'b0);
  endtask

  // Follow one frame of the main instance. The handshake happens on the next
  // edge. After the handshake, data is switched to nextData and valid is
  // dropped unless keepValid is set. A pulseCycle of 0 or more raises valid
  // with 8'h3C for a single edge in the middle of the frame.
  task automatic runFrame(input string tag, input logic [DW-1:0] word,
                          input logic keepValid, input logic [DW-1:0] nextData,
                          input int pulseCycle);
    for (int c = 0; c < FL1; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s tx c%0d", tag, c), tx, expBit(word, c / CPB));
      checkOutput($sformatf("%s ready c%0d", tag, c), ready, 1'b0);
      checkOutput($sformatf("%s busy c%0d", tag, c), busy, 1'b1);
      if (c == 0) begin
        data = nextData;
        if (!keepValid) valid = 1'b0;
      end
      if (c == pulseCycle) begin
        valid = 1'b1;
        data  = 8'h3C;
      end
      if ((pulseCycle >= 0) && (c == pulseCycle + 1)) valid = 1'b0;
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    data2  = '0;
    valid2 = 1'b0;

    // Hold clr for three cycles with valid high; no start bit may appear
    applyStimulus(8'hA5, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rst tx c%0d", c), tx, 1'b1);
      checkOutput($sformatf("rst ready c%0d", c), ready, 1'b1);
      checkOutput($sformatf("rst busy c%0d", c), busy, 1'b0);
      checkOutput($sformatf("rst tx2 c%0d", c), tx2, 1'b1);
    end
    applyStimulus(8'hA5, 1'b0, 1'b0);
    idleCheck("rst release");

    // Single frame
    $display("[TB] single frame 8'hA5");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    runFrame("a5", 8'hA5, 1'b0, 8'hA5, -1);
    idleCheck("a5 end");

    // Back-to-back frames: one IDLE cycle, then the next start bit
    $display("[TB] back-to-back 8'h00 then 8'hFF");
    applyStimulus(8'h00, 1'b1, 1'b0);
    runFrame("b2b0", 8'h00, 1'b1, 8'hFF, -1);
    idleCheck("b2b gap");
    runFrame("b2b1", 8'hFF, 1'b0, 8'hFF, -1);
    idleCheck("b2b end");

    // A valid pulse while busy is ignored, and no second frame follows
    $display("[TB] ignore valid while busy");
    applyStimulus(8'h81, 1'b1, 1'b0);
    runFrame("ign", 8'h81, 1'b0, 8'h81, 10);
    for (int c = 0; c < 6; c++) idleCheck($sformatf("ign idle%0d", c));

    // Abort during data bit 3 of 8'hF0, then send a fresh frame
    $display("[TB] abort mid-frame");
    applyStimulus(8'hF0, 1'b1, 1'b0);
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("abt tx c%0d", c), tx, expBit(8'hF0, c / CPB));
      if (c == 0) valid = 1'b0;
    end
    clr = 1'b1;
    @(posedge clk); #1;
    checkOutput("abt clr tx", tx, 1'b1);
    checkOutput("abt clr ready", ready, 1'b1);
    checkOutput("abt clr busy", busy, 1'b0);
    clr = 1'b0;
    idleCheck("abt after");
    applyStimulus(8'h55, 1'b1, 1'b0);
    runFrame("f55", 8'h55, 1'b0, 8'h55, -1);
    idleCheck("f55 end");

    // Word with an odd number of ones (sets the parity bit in parity builds)
    applyStimulus(8'h07, 1'b1, 1'b0);
    runFrame("f07", 8'h07, 1'b0, 8'h07, -1);
    idleCheck("f07 end");

    // Two stop bits on the second instance
    $display("[TB] two stop bits");
    data2  = 8'hA5;
    valid2 = 1'b1;
    for (int c = 0; c < FL2; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("sb2 tx c%0d", c), tx2, expBit(8'hA5, c / CPB));
      checkOutput($sformatf("sb2 ready c%0d", c), ready2, 1'b0);
      if (c == 0) valid2 = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput("sb2 end tx", tx2, 1'b1);
    checkOutput("sb2 end ready", ready2, 1'b1);
    checkOutput("sb2 end busy", busy2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
